// File: rtl/top_pc_pkg.sv
// Shared constants for the fetch front end:
// widths, field positions and the boot program.
package top_pc_pkg;

    localparam int PC_W      = 8;
    localparam int INSN_W    = 32;
    localparam int ROM_DEPTH = 64;
    localparam int ROM_AW    = $clog2(ROM_DEPTH);

    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int IMM_LSB = 20;
    localparam int IMM_MSB = 31;

    localparam logic [INSN_W-1:0] INSN_NOP = 32'h0000_0013;

    typedef logic [INSN_W-1:0] rom_t [ROM_DEPTH];

    localparam rom_t ROM_INIT = '{
        0:       32'h0050_0093,
        1:       32'h00A0_0113,
        2:       32'h0020_81B3,
        3:       32'hFFF0_0213,
        default: INSN_NOP
    };

endpackage

// File: rtl/top_pc_if.sv
// Fetch bundle: PC, raw instruction and
// decoded register/immediate fields.
interface top_pc_if;
    import top_pc_pkg::*;

    logic [PC_W-1:0]            next;
    logic [PC_W-1:0]            current;
    logic [RD_MSB-RD_LSB:0]     RD;
    logic [RS1_MSB-RS1_LSB:0]   RS1;
    logic [RS2_MSB-RS2_LSB:0]   RS2;
    logic [IMM_MSB-IMM_LSB:0]   IMM;
    logic [INSN_W-1:0]          out;

    modport master (
        output next, current, RD, RS1, RS2, IMM, out
    );

    modport slave (
        input next, current, RD, RS1, RS2, IMM, out
    );

endinterface

// File: rtl/top_pc_imem.sv
// Read-only instruction ROM with a combinational
// word-addressed read port.
module pc_imem
    import top_pc_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH
) (
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    output logic [INSN_W-1:0]        o_data
);

    // Asynchronous lookup of the boot program word.
    always_comb begin
        o_data = ROM_INIT[i_addr];
    end

endmodule

// File: rtl/top_pc.sv
// Sequential PC with ROM fetch and raw field
// extraction; no branches or stalls.
module top_pc
    import top_pc_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    top_pc_if.master  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]   r_current;
    logic [PC_W-1:0]   w_next;
    logic [INSN_W-1:0] w_insn;

    // Next fetch address; wraps naturally at 8 bits.
    always_comb begin
        w_next = r_current + PC_W'(4);
    end

    // PC register; reset wins over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_current <= '0;
        end else begin
            r_current <= w_next;
        end
    end

    pc_imem #(
        .DEPTH (DEPTH)
    ) u_imem (
        .i_addr (r_current[AW+1:2]),
        .o_data (w_insn)
    );

    // Drive the bundle; fields are plain slices.
    always_comb begin
        bus.next    = w_next;
        bus.current = r_current;
        bus.out     = w_insn;
        bus.RD      = w_insn[RD_MSB:RD_LSB];
        bus.RS1     = w_insn[RS1_MSB:RS1_LSB];
        bus.RS2     = w_insn[RS2_MSB:RS2_LSB];
        bus.IMM     = w_insn[IMM_MSB:IMM_LSB];
    end

endmodule

// File: tb/tb_top_pc.sv
// Randomised self-checking bench for top_pc
// against an arithmetic PC/ROM model.
module tb_top_pc;

    logic clk;
    logic reset;

    int n_chk;
    int n_err;
    int ref_pc;

    top_pc_if bus ();

    top_pc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_insn(input int pc);
        case ((pc % 256) / 4)
            0:       return 32'h0050_0093;
            1:       return 32'h00A0_0113;
            2:       return 32'h0020_81B3;
            3:       return 32'hFFF0_0213;
            default: return 32'h0000_0013;
        endcase
    endfunction

    // One clock edge: update the model, then settle.
    task automatic step();
        @(posedge clk);
        if (reset) ref_pc = 0;
        else       ref_pc = (ref_pc + 4) % 256;
        #1;
    endtask

    task automatic chk_all(input string tag);
        logic [31:0] ins;
        ins = ref_insn(ref_pc);
        chk({tag, ".cur"}, 32'(bus.current), 32'(ref_pc));
        chk({tag, ".next"}, 32'(bus.next), 32'((ref_pc + 4) % 256));
        chk({tag, ".out"}, bus.out, ins);
        chk({tag, ".rd"}, 32'(bus.RD), (ins >> 7) & 32'd31);
        chk({tag, ".rs1"}, 32'(bus.RS1), (ins >> 15) & 32'd31);
        chk({tag, ".rs2"}, 32'(bus.RS2), (ins >> 20) & 32'd31);
        chk({tag, ".imm"}, 32'(bus.IMM), (ins >> 20) & 32'hFFF);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        ref_pc = 0;
        reset  = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step();
            chk("rst.cur", 32'(bus.current), 32'h00);
            chk("rst.next", 32'(bus.next), 32'h04);
            chk("rst.out", bus.out, 32'h0050_0093);
            chk("rst.rd", 32'(bus.RD), 32'd1);
            chk("rst.rs1", 32'(bus.RS1), 32'd0);
            chk("rst.rs2", 32'(bus.RS2), 32'd5);
            chk("rst.imm", 32'(bus.IMM), 32'h005);
        end

        step();
        step();
        chk_all("rst2");
        reset = 1'b0;

        step();
        chk("seq4.cur", 32'(bus.current), 32'd4);
        chk("seq4.out", bus.out, 32'h00A0_0113);
        chk("seq4.rd", 32'(bus.RD), 32'd2);
        chk("seq4.rs2", 32'(bus.RS2), 32'd10);
        chk("seq4.imm", 32'(bus.IMM), 32'h00A);
        step();
        chk("seq8.cur", 32'(bus.current), 32'd8);
        chk("seq8.out", bus.out, 32'h0020_81B3);
        chk("seq8.rd", 32'(bus.RD), 32'd3);
        chk("seq8.rs1", 32'(bus.RS1), 32'd1);
        chk("seq8.rs2", 32'(bus.RS2), 32'd2);
        chk("seq8.imm", 32'(bus.IMM), 32'h002);
        step();
        chk("seq12.cur", 32'(bus.current), 32'd12);
        chk("seq12.out", bus.out, 32'hFFF0_0213);
        chk("seq12.rd", 32'(bus.RD), 32'd4);
        chk("seq12.rs1", 32'(bus.RS1), 32'd0);
        chk("seq12.rs2", 32'(bus.RS2), 32'd31);
        chk("seq12.imm", 32'(bus.IMM), 32'hFFF);
        step();
        chk("seq16.cur", 32'(bus.current), 32'd16);
        chk("seq16.out", bus.out, 32'h0000_0013);

        for (int i = 4; i < 63; i++) begin
            step();
            chk_all("run");
        end
        chk("wrap.cur", 32'(bus.current), 32'hFC);
        chk("wrap.next", 32'(bus.next), 32'h00);
        step();
        chk("wrap0.cur", 32'(bus.current), 32'h00);
        chk("wrap0.out", bus.out, 32'h0050_0093);

        for (int i = 0; i < 8; i++) step();
        chk("pre.cur", 32'(bus.current), 32'h20);
        reset = 1'b1;
        step();
        chk("mid.cur", 32'(bus.current), 32'h00);
        chk_all("mid");
        reset = 1'b0;
        step();
        chk("rel.cur", 32'(bus.current), 32'h04);

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            step();
            chk_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
